// File: rtl/hazard_controller_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package hazard_controller_pkg;

    // Controller sequencing states
    typedef enum logic [1:0] {
        HZ_INIT,
        HZ_RUN,
        HZ_MEM_WAIT
    } hz_state_t;

    // Operand forward select encoding used by the E-stage muxes
    typedef logic [1:0] fwd_sel_t;
    localparam fwd_sel_t FWD_RF  = 2'b00;  // value read from the register file
    localparam fwd_sel_t FWD_WB  = 2'b01;  // result from the W stage
    localparam fwd_sel_t FWD_MEM = 2'b10;  // ALU result sitting in the M stage

    localparam int REG_W = 5;

    // RAW forward select for one E-stage source register. M is younger than W,
    // so it holds the newer value and wins when both match. x0 is never forwarded.
    function automatic fwd_sel_t fwd_select(
        input logic             rw_m,
        input logic [REG_W-1:0] rd_m,
        input logic             rw_w,
        input logic [REG_W-1:0] rd_w,
        input logic [REG_W-1:0] rs
    );
        fwd_sel_t sel;
        sel = FWD_RF;
        if (rw_m && (rd_m != '0) && (rd_m == rs))
            sel = FWD_MEM;
        else if (rw_w && (rd_w != '0) && (rd_w == rs))
            sel = FWD_WB;
        return sel;
    endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Single saturating event counter with synchronous clear.
module hazard_perf_cnt #(
    parameter int PERF_W = 32
) (
    input  logic              i_clk,
    input  logic              i_clear,
    input  logic              i_inc,
    output logic [PERF_W-1:0] o_count
);

    logic [PERF_W-1:0] r_count;

    // Count events, sticking at all-ones instead of wrapping
    always_ff @(posedge i_clk) begin
        if (i_clear)
            r_count <= '0;
        else if (i_inc && (r_count != '1))
            r_count <= r_count + PERF_W'(1);
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_controller.sv
// Hazard and sequencing controller for the 5-stage core.
// Combinational forwarding / load-use stall / branch flush, plus a post-reset
// scrub and a data-memory wait FSM with bus-error timeout.
// Optional performance counters are built when HAZARD_PERF_EN is defined;
// otherwise the perf ports read as zero and no counter flops exist.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int INIT_CYCLES = 3,
    parameter int MEM_TIMEOUT = 64,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_W-1:0]  Rs1D,
    input  logic [REG_W-1:0]  Rs2D,
    input  logic [REG_W-1:0]  Rs1E,
    input  logic [REG_W-1:0]  Rs2E,
    input  logic [REG_W-1:0]  RdE,
    input  logic [REG_W-1:0]  RdM,
    input  logic [REG_W-1:0]  RdW,
    input  logic              ResultSrcE0,
    input  logic              PCSrcE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              MemReqM,
    input  logic              dmem_ready,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushW,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardEE,
    output logic              bus_err,
    output logic [PERF_W-1:0] perf_stall,
    output logic [PERF_W-1:0] perf_flush,
    output logic [PERF_W-1:0] perf_memwait
);

    localparam int INIT_W = $clog2(INIT_CYCLES + 1);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    hz_state_t         r_state;
    hz_state_t         w_next_state;
    logic [INIT_W-1:0] r_init_cnt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_bus_err;

    logic              w_lw_stall;
    logic              w_init_done;
    logic              w_wait_tmo;
    fwd_sel_t          w_fwd_a;
    fwd_sel_t          w_fwd_b;

    // Load in E whose destination is read by the instruction in D
    assign w_lw_stall  = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign w_init_done = (r_init_cnt == INIT_W'(INIT_CYCLES - 1));
    assign w_wait_tmo  = (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

    assign w_fwd_a = fwd_select(RegWriteM, RdM, RegWriteW, RdW, Rs1E);
    assign w_fwd_b = fwd_select(RegWriteM, RdM, RegWriteW, RdW, Rs2E);

    // State register and its counters; reset wins from any state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= HZ_INIT;
            r_init_cnt <= '0;
            r_wait_cnt <= '0;
            r_bus_err  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                HZ_INIT: begin
                    if (!w_init_done)
                        r_init_cnt <= r_init_cnt + INIT_W'(1);
                end
                HZ_MEM_WAIT: begin
                    if (dmem_ready || w_wait_tmo)
                        r_wait_cnt <= '0;
                    else
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    // Access abandoned: flag it and let the pipe move on
                    if (!dmem_ready && w_wait_tmo)
                        r_bus_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Next state and pipeline control outputs
    always_comb begin
        w_next_state = r_state;
        StallF       = 1'b0;
        StallD       = 1'b0;
        StallE       = 1'b0;
        StallM       = 1'b0;
        FlushD       = 1'b0;
        FlushE       = 1'b0;
        FlushW       = 1'b0;
        ForwardAE    = FWD_RF;
        ForwardEE    = FWD_RF;
        case (r_state)
            HZ_INIT: begin
                // Hold fetch and keep bubbles flowing until the pipe is clean
                StallF = 1'b1;
                FlushD = 1'b1;
                FlushE = 1'b1;
                FlushW = 1'b1;
                if (w_init_done)
                    w_next_state = HZ_RUN;
            end
            HZ_RUN: begin
                ForwardAE = w_fwd_a;
                ForwardEE = w_fwd_b;
                StallF    = w_lw_stall;
                StallD    = w_lw_stall;
                FlushD    = PCSrcE;
                FlushE    = w_lw_stall | PCSrcE;
                // M is not frozen yet this cycle, so the normal controls still apply
                if (MemReqM && !dmem_ready)
                    w_next_state = HZ_MEM_WAIT;
            end
            HZ_MEM_WAIT: begin
                // Freeze F..M; W gets bubbles so the stalled access retires only once.
                // Redirects/load-use wait in the frozen E stage until RUN resumes.
                ForwardAE = w_fwd_a;
                ForwardEE = w_fwd_b;
                StallF    = 1'b1;
                StallD    = 1'b1;
                StallE    = 1'b1;
                StallM    = 1'b1;
                FlushW    = 1'b1;
                if (dmem_ready || w_wait_tmo)
                    w_next_state = HZ_RUN;
            end
            default: w_next_state = HZ_INIT;
        endcase
    end

    assign bus_err = r_bus_err;

`ifdef HAZARD_PERF_EN
    logic w_inc_stall;
    logic w_inc_flush;
    logic w_inc_memwait;

    assign w_inc_stall   = StallF && (r_state != HZ_INIT);
    assign w_inc_flush   = PCSrcE && (r_state == HZ_RUN);
    assign w_inc_memwait = (r_state == HZ_MEM_WAIT);

    hazard_perf_cnt #(.PERF_W(PERF_W)) u_perf_stall (
        .i_clk   (clk),
        .i_clear (reset),
        .i_inc   (w_inc_stall),
        .o_count (perf_stall)
    );

    hazard_perf_cnt #(.PERF_W(PERF_W)) u_perf_flush (
        .i_clk   (clk),
        .i_clear (reset),
        .i_inc   (w_inc_flush),
        .o_count (perf_flush)
    );

    hazard_perf_cnt #(.PERF_W(PERF_W)) u_perf_memwait (
        .i_clk   (clk),
        .i_clear (reset),
        .i_inc   (w_inc_memwait),
        .o_count (perf_memwait)
    );
`else
    assign perf_stall   = '0;
    assign perf_flush   = '0;
    assign perf_memwait = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed steps followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_hazard_controller;

    localparam int INIT_CYCLES = 3;
    localparam int MEM_TIMEOUT = 64;
    localparam int PERF_W      = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, MemReqM, dmem_ready;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0] ForwardAE, ForwardEE;
    logic       bus_err;
    logic [PERF_W-1:0] perf_stall, perf_flush, perf_memwait;

    hazard_controller #(
        .INIT_CYCLES (INIT_CYCLES),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .PERF_W      (PERF_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .RdE         (RdE),
        .RdM         (RdM),
        .RdW         (RdW),
        .ResultSrcE0 (ResultSrcE0),
        .PCSrcE      (PCSrcE),
        .RegWriteM   (RegWriteM),
        .RegWriteW   (RegWriteW),
        .MemReqM     (MemReqM),
        .dmem_ready  (dmem_ready),
        .StallF      (StallF),
        .StallD      (StallD),
        .StallE      (StallE),
        .StallM      (StallM),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .FlushW      (FlushW),
        .ForwardAE   (ForwardAE),
        .ForwardEE   (ForwardEE),
        .bus_err     (bus_err),
        .perf_stall  (perf_stall),
        .perf_flush  (perf_flush),
        .perf_memwait(perf_memwait)
    );

    // Reference model: scrub cycles left, waiting flag, cycles spent waiting
    int      m_init_left;
    bit      m_waiting;
    int      m_wait_cycles;
    bit      m_berr;
    longint  m_ps, m_pf, m_pm;
    bit      m_valid = 1'b0;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic longint sat_inc(input longint v);
        return (v < 64'hFFFF_FFFF) ? v + 1 : v;
    endfunction

    // Compare every output against the model for the current cycle
    task automatic check_outputs(input string tag);
        logic [6:0]  ctl;
        logic [1:0]  fa, fb;
        logic [95:0] perf;
        bit          lw;
        fa = 2'b00;
        fb = 2'b00;
        if (m_init_left > 0) begin
            ctl = 7'b1000111;
        end else if (m_waiting) begin
            ctl = 7'b1111001;
            fa  = ref_fwd(Rs1E);
            fb  = ref_fwd(Rs2E);
        end else begin
            lw  = ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
            ctl = {lw, lw, 1'b0, 1'b0, PCSrcE, lw | PCSrcE, 1'b0};
            fa  = ref_fwd(Rs1E);
            fb  = ref_fwd(Rs2E);
        end
        chk({tag, "/ctl"},
            {84'd0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE, ForwardEE, bus_err},
            {84'd0, ctl, fa, fb, m_berr});
`ifdef HAZARD_PERF_EN
        perf = {m_ps[31:0], m_pf[31:0], m_pm[31:0]};
`else
        perf = '0;
`endif
        chk({tag, "/perf"}, {perf_stall, perf_flush, perf_memwait}, perf);
    endtask

    // Advance the model across one rising edge using the inputs held there
    task automatic model_edge();
        bit lw;
        if (reset) begin
            m_init_left   = INIT_CYCLES;
            m_waiting     = 1'b0;
            m_wait_cycles = 0;
            m_berr        = 1'b0;
            m_ps = 0; m_pf = 0; m_pm = 0;
            m_valid       = 1'b1;
        end else if (m_init_left > 0) begin
            m_init_left--;
        end else if (m_waiting) begin
            m_ps = sat_inc(m_ps);
            m_pm = sat_inc(m_pm);
            m_wait_cycles++;
            if (dmem_ready) begin
                m_waiting = 1'b0;
                m_wait_cycles = 0;
            end else if (m_wait_cycles == MEM_TIMEOUT) begin
                m_berr = 1'b1;
                m_waiting = 1'b0;
                m_wait_cycles = 0;
            end
        end else begin
            lw = ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
            if (lw) m_ps = sat_inc(m_ps);
            if (PCSrcE) m_pf = sat_inc(m_pf);
            if (MemReqM && !dmem_ready) m_waiting = 1'b1;
        end
    endtask

    task automatic cyc(input string tag);
        @(negedge clk);
        if (m_valid) check_outputs(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0;
        RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE0 = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
        MemReqM = 0; dmem_ready = 1;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        cyc("pre_reset");
        reset = 1'b0;

        // 1: post-reset scrub, then quiet RUN
        repeat (INIT_CYCLES) cyc("t1_init");
        cyc("t1_run");
        chk("t1_run_stallF", {95'd0, StallF}, 96'd0);

        // 2: forwarding priority, M over W, then W alone
        RegWriteM = 1; RdM = 5; Rs1E = 5; RegWriteW = 1; RdW = 5; Rs2E = 5;
        cyc("t2_fwd_mem");
        RdM = 0;
        cyc("t2_fwd_wb");
        idle_inputs();

        // 3: load-use stall, then x0 destination does not stall
        ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
        cyc("t3_lwstall");
        RdE = 0;
        cyc("t3_rd0");

        // 4: redirect together with load-use
        RdE = 7; PCSrcE = 1;
        cyc("t4_flush_lw");
        idle_inputs();

        // 5: short memory wait with a redirect held across it
        MemReqM = 1; dmem_ready = 0;
        cyc("t5_req");
        PCSrcE = 1;
        repeat (3) cyc("t5_wait");
        dmem_ready = 1;
        cyc("t5_ready");
        MemReqM = 0;
        cyc("t5_resume");
        idle_inputs();
        cyc("t5_idle");

        // 6: timeout sets sticky bus error; reset mid-wait clears it
        MemReqM = 1; dmem_ready = 0;
        repeat (MEM_TIMEOUT + 2) cyc("t6_timeout");
        chk("t6_berr_set", {95'd0, bus_err}, {95'd0, 1'b1});
        idle_inputs();
        repeat (3) cyc("t6_sticky");
        MemReqM = 1; dmem_ready = 0;
        repeat (10) cyc("t6_wait");
        reset = 1'b1;
        cyc("t6_reset");
        reset = 1'b0;
        chk("t6_berr_clr", {95'd0, bus_err}, 96'd0);
        chk("t6_init_stall", {95'd0, StallF}, {95'd0, 1'b1});
        idle_inputs();
        repeat (INIT_CYCLES + 1) cyc("t6_reinit");

        // Random traffic, small register range to force frequent matches
        for (int i = 0; i < 3000; i++) begin
            Rs1D = 5'($urandom_range(0, 7));
            Rs2D = 5'($urandom_range(0, 7));
            Rs1E = 5'($urandom_range(0, 7));
            Rs2E = 5'($urandom_range(0, 7));
            RdE  = 5'($urandom_range(0, 7));
            RdM  = 5'($urandom_range(0, 7));
            RdW  = 5'($urandom_range(0, 7));
            ResultSrcE0 = ($urandom_range(0, 3) == 0);
            PCSrcE      = ($urandom_range(0, 4) == 0);
            RegWriteM   = $urandom_range(0, 1) != 0;
            RegWriteW   = $urandom_range(0, 1) != 0;
            MemReqM     = ($urandom_range(0, 9) < 3);
            dmem_ready  = (i % 500 > 400) ? 1'b0 : ($urandom_range(0, 9) < 7);
            reset       = ($urandom_range(0, 199) == 0);
            cyc("rand");
        end
        reset = 1'b0;
        idle_inputs();
        cyc("final");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
